cu_decode_queue: RTL
====================

CU_DECODE_QUEUE -- requirements
Module: cu_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered decoded entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default 32, instruction word width (word_t).
REQ-003 The block SHALL have port CLK  input  1  rising-edge clock; one clock, synchronous active-high reset.
REQ-004 The block SHALL have port RST  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port flush  input  1  discard all queued entries.
REQ-006 The block SHALL have port in_valid  input  1  instr valid.
REQ-007 The block SHALL have port in_ready  output  1  queue can accept.
REQ-008 The block SHALL have port instr  input  CW  raw instruction.
REQ-009 The block SHALL have port out_valid  output  1  head entry valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes head.
REQ-011 The block SHALL have port out_ctrl  output  ctrl_t  decoded bundle: ALUSrc, ALUOp, RegSel, RegDst, RegWr, ExtOp, PCSrc, dREN, dWEN.
REQ-012 The block SHALL have port out_instr  output  CW  raw instruction of head entry.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-014 The block SHALL have port halt  output  1  sticky halt seen (only with CU_HALT_EN).

Function
REQ-015 Decode SHALL be combinational at enqueue per the team ISA decode table; the decoded ctrl_t and raw instr are stored together.
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be (count < DEPTH) and SHALL have no combinational path from out_ready; a full queue refuses a push even if a pop occurs that cycle.
REQ-018 out_valid SHALL be (count != 0); when count == 0, out_ctrl and out_instr SHALL read all-zero.
REQ-019 Latency: an instruction pushed in cycle N SHALL appear at the head no earlier than cycle N+1 (no bypass when empty).
REQ-020 Simultaneous push and pop (not full, not empty) SHALL leave count unchanged and preserve FIFO order.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count SHALL saturate at neither bound (over/underflow is prevented by REQ-016/017).
REQ-022 flush SHALL empty the queue at the next edge (count=0, pointers=0) and SHALL override any push or pop in the same cycle.
REQ-023 Unknown opcodes SHALL decode to an all-zero ctrl_t (RegWr=0, dREN=0, dWEN=0) and still be queued.

Reset
REQ-024 On RST at an edge: count=0, pointers=0, out_valid=0, in_ready=1, halt=0; stored entries need not be cleared.
REQ-025 RST asserted mid-traffic SHALL take precedence over flush, push and pop.

Configuration
REQ-026 Macro CU_HALT_EN defined: pushing opcode HALT (6'h3F) SHALL set halt at the next edge; halt is sticky until RST (flush does not clear it); while halt=1, in_ready SHALL be 0; the HALT entry itself is queued and drains normally.
REQ-027 CU_HALT_EN undefined: no halt port; opcode 6'h3F decodes per REQ-023; in_ready per REQ-017 only.

Structure
REQ-028 ctrl_t (packed struct of the nine control fields), opcode/funct enums and the HALT opcode constant SHALL live in control_unit_pkg.
REQ-029 Decode SHALL be a sub-module cu_decode (pure combinational, instr -> ctrl_t); storage, pointers and halt logic SHALL be in cu_decode_queue.

Verification
REQ-030 Reset then push 0x00851021 (addu $2,$4,$5) -> next cycle out_valid=1, out_ctrl.RegWr=1, RegDst=2, dREN=0, dWEN=0, count=1.
REQ-031 Push 4 instrs with out_ready=0 (DEPTH=4) -> count=4, in_ready=0; 5th in_valid ignored; drain yields original order.
REQ-032 Full queue, out_ready=1 and in_valid=1 same cycle -> pop only, count 4->3; next cycle push accepted, count=4.
REQ-033 count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_ctrl=0.
REQ-034 Push 0x8C820004 (lw) then 0xAC820004 (sw) -> heads show dREN=1/RegWr=1 then dWEN=1/RegWr=0.
REQ-035 CU_HALT_EN: push 0xFFFFFFFF -> halt=1 and in_ready=0 next cycle; flush leaves halt=1; RST clears halt and in_ready=1.

Source files
------------

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - control bundle type, opcode/funct/ALU encodings and HALT opcode
package control_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
    OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
    OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW  = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADDU = 6'h21,
    FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26,
    FN_NOR  = 6'h27, FN_SLT = 6'h2A
  } funct_t;

  // ALU_ADD is zero so an all-zero bundle stays a harmless add
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_LUI = 4'd9
  } aluop_t;

  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  // Write-back source select
  localparam logic [1:0] RS_ALU = 2'd0, RS_MEM = 2'd1, RS_PC4 = 2'd2, RS_LUI = 2'd3;
  // Destination register select
  localparam logic [1:0] RD_RT = 2'd0, RD_RA = 2'd1, RD_RD = 2'd2;
  // Next-PC source
  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_JR = 2'd3;

  typedef struct packed {
    logic       ALUSrc;
    aluop_t     ALUOp;
    logic [1:0] RegSel;
    logic [1:0] RegDst;
    logic       RegWr;
    logic       ExtOp;
    logic [1:0] PCSrc;
    logic       dREN;
    logic       dWEN;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational instruction to ctrl_t decoder
module cu_decode
  import control_unit_pkg::*;
(
  input  word_t instr_i,
  output ctrl_t ctrl_o
);

  logic [19:0] unused_bits;
  assign unused_bits = instr_i[25:6];

  // Decode table; anything not listed (opcode or R-type funct) yields an all-zero bundle
  always_comb begin
    ctrl_o = '0;
    case (instr_i[31:26])
      OP_RTYPE: begin
        ctrl_o.RegDst = RD_RD;
        ctrl_o.RegWr  = 1'b1;
        case (instr_i[5:0])
          FN_ADDU: ctrl_o.ALUOp = ALU_ADD;
          FN_SUBU: ctrl_o.ALUOp = ALU_SUB;
          FN_AND:  ctrl_o.ALUOp = ALU_AND;
          FN_OR:   ctrl_o.ALUOp = ALU_OR;
          FN_XOR:  ctrl_o.ALUOp = ALU_XOR;
          FN_NOR:  ctrl_o.ALUOp = ALU_NOR;
          FN_SLT:  ctrl_o.ALUOp = ALU_SLT;
          FN_SLL:  ctrl_o.ALUOp = ALU_SLL;
          FN_SRL:  ctrl_o.ALUOp = ALU_SRL;
          FN_JR: begin
            ctrl_o.RegDst = RD_RT;
            ctrl_o.RegWr  = 1'b0;
            ctrl_o.PCSrc  = PC_JR;
          end
          default: ctrl_o = '0;
        endcase
      end
      OP_ADDIU: begin ctrl_o.ALUSrc = 1'b1; ctrl_o.ExtOp = 1'b1; ctrl_o.RegWr = 1'b1; end
      OP_SLTI: begin
        ctrl_o.ALUSrc = 1'b1; ctrl_o.ExtOp = 1'b1; ctrl_o.RegWr = 1'b1; ctrl_o.ALUOp = ALU_SLT;
      end
      OP_ANDI: begin ctrl_o.ALUSrc = 1'b1; ctrl_o.RegWr = 1'b1; ctrl_o.ALUOp = ALU_AND; end
      OP_ORI:  begin ctrl_o.ALUSrc = 1'b1; ctrl_o.RegWr = 1'b1; ctrl_o.ALUOp = ALU_OR; end
      OP_LUI: begin
        ctrl_o.ALUSrc = 1'b1; ctrl_o.RegWr = 1'b1; ctrl_o.ALUOp = ALU_LUI; ctrl_o.RegSel = RS_LUI;
      end
      OP_LW: begin
        ctrl_o.ALUSrc = 1'b1; ctrl_o.ExtOp = 1'b1; ctrl_o.RegWr = 1'b1;
        ctrl_o.RegSel = RS_MEM; ctrl_o.dREN = 1'b1;
      end
      OP_SW:  begin ctrl_o.ALUSrc = 1'b1; ctrl_o.ExtOp = 1'b1; ctrl_o.dWEN = 1'b1; end
      OP_BEQ, OP_BNE: begin ctrl_o.ALUOp = ALU_SUB; ctrl_o.ExtOp = 1'b1; ctrl_o.PCSrc = PC_BR; end
      OP_J:   ctrl_o.PCSrc = PC_JMP;
      OP_JAL: begin
        ctrl_o.PCSrc = PC_JMP; ctrl_o.RegDst = RD_RA; ctrl_o.RegSel = RS_PC4; ctrl_o.RegWr = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/cu_decode_queue.sv
// rtl/cu_decode_queue.sv - decode-at-enqueue instruction FIFO; CU_HALT_EN adds sticky halt
module cu_decode_queue
  import control_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output ctrl_t                    out_ctrl,
  output logic [CW-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]   count
`ifdef CU_HALT_EN
  ,
  output logic                     halt
`endif
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  ctrl_t           ctrl_mem [DEPTH];
  logic [CW-1:0]   instr_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  ctrl_t           dec_ctrl;
  logic            push, pop;

  // Opcode sits in bits 31:26, so CW is expected to be at least 32
  cu_decode u_decode (
    .instr_i (instr[31:0]),
    .ctrl_o  (dec_ctrl)
  );

`ifdef CU_HALT_EN
  logic halt_q, halt_d;
  assign in_ready = (count_q < DEPTH_C) && !halt_q;
  assign halt     = halt_q;
  // Halt latches on an accepted HALT push that is not cancelled by flush
  always_comb begin
    halt_d = halt_q;
    if (push && !flush && (instr[31:26] == HALT_OPCODE)) halt_d = 1'b1;
  end
  // Sticky halt register, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`else
  assign in_ready = (count_q < DEPTH_C);
`endif

  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ctrl  = out_valid ? ctrl_mem[rd_ptr_q]  : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign count     = count_q;

  // Pointer and occupancy next state; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers; reset takes precedence over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written on an accepted, non-flushed push; contents are not reset
  always_ff @(posedge CLK) begin
    if (push && !flush && !RST) begin
      ctrl_mem[wr_ptr_q]  <= dec_ctrl;
      instr_mem[wr_ptr_q] <= instr;
    end
  end

endmodule
